// File: rtl/mult_taint_pkg.sv
// Shared definitions for the taint-tracking shift-add multiplier datapath.
// Provides register-width helpers, the running-sum operation encoding and
// the priority decoder that selects one running-sum operation per cycle.
package mult_taint_pkg;

  // Running sum keeps one extra bit above the product for the adder carry.
  function automatic int rs_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  localparam logic [1:0] RS_HOLD = 2'd0;
  localparam logic [1:0] RS_CLR  = 2'd1;
  localparam logic [1:0] RS_ADD  = 2'd2;
  localparam logic [1:0] RS_SHR  = 2'd3;

  // Only one running-sum action per cycle: clear beats add beats shift.
  function automatic logic [1:0] rs_op_decode(input logic clr, input logic ld, input logic shr);
    logic [1:0] op;
    op = RS_HOLD;
    if (clr)      op = RS_CLR;
    else if (ld)  op = RS_ADD;
    else if (shr) op = RS_SHR;
    return op;
  endfunction

endpackage

// File: rtl/taint_word_reg.sv
// Word register with a single taint bit, used for the multiplicand and multiplier.
// Ports: clk/rst (async active-low), i_load/i_load_t strobe and its taint,
//        i_d/i_d_t data and its taint, o_q/o_q_t stored value and taint.
module taint_word_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_load_t,
  input  logic [W-1:0] i_d,
  input  logic         i_d_t,
  output logic [W-1:0] o_q,
  output logic         o_q_t
);

  logic [W-1:0] r_q;
  logic         r_q_t;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q   <= '0;
      r_q_t <= 1'b0;
    end else begin
      if (i_load) r_q <= i_d;
      // A tainted strobe taints the word whether or not it fired; only a
      // clean load can lower the taint.
      if (i_load_t)    r_q_t <= 1'b1;
      else if (i_load) r_q_t <= i_d_t;
    end
  end

  assign o_q   = r_q;
  assign o_q_t = r_q_t;

endmodule

// File: rtl/multiplier_datapath_taint_track_word.sv
// Shift-add multiplier datapath: MD/MR operand registers, running sum RS and
// captured product, each with a word-level taint bit.
// Ports: control strobes (mdld, mrld, rsclear, rsload, rsshr, productDone) with
//        taints; operands in; multiplierReg back to control; product/valid out.
module multiplier_datapath_taint_track_word
  import mult_taint_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     multiplicand_in,
  input  logic                 multiplicand_in_t,
  input  logic [WIDTH-1:0]     multiplier_in,
  input  logic                 multiplier_in_t,
  input  logic                 mdld,
  input  logic                 mdld_t,
  input  logic                 mrld,
  input  logic                 mrld_t,
  input  logic                 rsclear,
  input  logic                 rsclear_t,
  input  logic                 rsload,
  input  logic                 rsload_t,
  input  logic                 rsshr,
  input  logic                 rsshr_t,
  input  logic                 productDone,
  input  logic                 productDone_t,
  output logic [WIDTH-1:0]     multiplierReg,
  output logic                 multiplierReg_t,
  output logic [2*WIDTH-1:0]   product,
  output logic                 product_t,
  output logic                 product_valid,
  output logic                 product_valid_t
);

  localparam int RSW = rs_w(WIDTH);
  localparam int PW  = prod_w(WIDTH);

  logic [WIDTH-1:0] w_md;
  logic             w_md_t;

  taint_word_reg #(.W(WIDTH)) u_md (
    .clk      (clk),
    .rst      (rst),
    .i_load   (mdld),
    .i_load_t (mdld_t),
    .i_d      (multiplicand_in),
    .i_d_t    (multiplicand_in_t),
    .o_q      (w_md),
    .o_q_t    (w_md_t)
  );

  taint_word_reg #(.W(WIDTH)) u_mr (
    .clk      (clk),
    .rst      (rst),
    .i_load   (mrld),
    .i_load_t (mrld_t),
    .i_d      (multiplier_in),
    .i_d_t    (multiplier_in_t),
    .o_q      (multiplierReg),
    .o_q_t    (multiplierReg_t)
  );

  logic [RSW-1:0]   r_rs;
  logic             r_rs_t;
  logic [RSW-1:0]   w_rs_nxt;
  logic             w_rs_t_nxt;
  logic [1:0]       w_rs_op;
  logic [WIDTH:0]   w_sum;
  logic [PW-1:0]    w_rs_shr_prod;

  logic [PW-1:0]    r_product;
  logic             r_product_t;
  logic             r_product_valid;
  logic             r_product_valid_t;

  // Add uses RS[2W-1:W] only; a stale carry in RS[2W] is overwritten.
  assign w_sum         = {1'b0, r_rs[PW-1:WIDTH]} + {1'b0, w_md};
  // Product view of RS after a right shift, for capture on the final shift.
  assign w_rs_shr_prod = r_rs[PW:1];

  always_comb begin
    w_rs_op    = rs_op_decode(rsclear, rsload, rsshr);
    w_rs_nxt   = r_rs;
    w_rs_t_nxt = r_rs_t;
    case (w_rs_op)
      RS_CLR: begin
        w_rs_nxt   = '0;
        w_rs_t_nxt = 1'b0;
      end
      RS_ADD: begin
        w_rs_nxt   = {w_sum, r_rs[WIDTH-1:0]};
        w_rs_t_nxt = r_rs_t | w_md_t;
      end
      RS_SHR: begin
        w_rs_nxt   = {1'b0, r_rs[RSW-1:1]};
      end
      default: ;
    endcase
    // Any tainted strobe, even one that lost priority or did not fire,
    // contaminates the running sum.
    w_rs_t_nxt = w_rs_t_nxt | rsclear_t | rsload_t | rsshr_t;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rs   <= '0;
      r_rs_t <= 1'b0;
    end else begin
      r_rs   <= w_rs_nxt;
      r_rs_t <= w_rs_t_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_product         <= '0;
      r_product_t       <= 1'b0;
      r_product_valid   <= 1'b0;
      r_product_valid_t <= 1'b0;
    end else begin
      // Capture takes precedence over the valid clear if both arrive together.
      if (productDone) begin
        r_product       <= rsshr ? w_rs_shr_prod : r_rs[PW-1:0];
        r_product_valid <= 1'b1;
      end else if (mdld || rsclear) begin
        r_product_valid <= 1'b0;
      end
      if (productDone_t) begin
        r_product_t       <= 1'b1;
        r_product_valid_t <= 1'b1;
      end else if (productDone) begin
        r_product_t       <= r_rs_t | rsshr_t;
        r_product_valid_t <= 1'b0;
      end
    end
  end

  assign product         = r_product;
  assign product_t       = r_product_t;
  assign product_valid   = r_product_valid;
  assign product_valid_t = r_product_valid_t;

endmodule

// File: tb/tb_multiplier_datapath_taint_track_word.sv
// Self-checking bench for the taint-tracking multiplier datapath.
// Directed cases plus randomized multiplies, checked against A*B and a
// taint model derived from which strobes were tainted.
module tb_multiplier_datapath_taint_track_word;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic [W-1:0]   multiplicand_in;
  logic           multiplicand_in_t;
  logic [W-1:0]   multiplier_in;
  logic           multiplier_in_t;
  logic           mdld, mdld_t, mrld, mrld_t;
  logic           rsclear, rsclear_t, rsload, rsload_t, rsshr, rsshr_t;
  logic           productDone, productDone_t;
  logic [W-1:0]   multiplierReg;
  logic           multiplierReg_t;
  logic [2*W-1:0] product;
  logic           product_t;
  logic           product_valid;
  logic           product_valid_t;

  int n_checks = 0;
  int n_errors = 0;

  multiplier_datapath_taint_track_word #(.WIDTH(W)) dut (
    .clk               (clk),
    .rst               (rst),
    .multiplicand_in   (multiplicand_in),
    .multiplicand_in_t (multiplicand_in_t),
    .multiplier_in     (multiplier_in),
    .multiplier_in_t   (multiplier_in_t),
    .mdld              (mdld),
    .mdld_t            (mdld_t),
    .mrld              (mrld),
    .mrld_t            (mrld_t),
    .rsclear           (rsclear),
    .rsclear_t         (rsclear_t),
    .rsload            (rsload),
    .rsload_t          (rsload_t),
    .rsshr             (rsshr),
    .rsshr_t           (rsshr_t),
    .productDone       (productDone),
    .productDone_t     (productDone_t),
    .multiplierReg     (multiplierReg),
    .multiplierReg_t   (multiplierReg_t),
    .product           (product),
    .product_t         (product_t),
    .product_valid     (product_valid),
    .product_valid_t   (product_valid_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_strobes();
    mdld = 0; mdld_t = 0; mrld = 0; mrld_t = 0;
    rsclear = 0; rsclear_t = 0; rsload = 0; rsload_t = 0;
    rsshr = 0; rsshr_t = 0; productDone = 0; productDone_t = 0;
  endtask

  // Full shift-add multiply driven the way the control block would.
  // inj inserts one cycle with rsload_t=1 but rsload=0 (data unchanged).
  task automatic run_mult(input int a, input bit at, input int b, input bit bt, input bit inj,
                          input string tag);
    logic [W-1:0] bv;
    bit           exp_pt;
    bv = b[W-1:0];
    multiplicand_in = a[W-1:0]; multiplicand_in_t = at;
    multiplier_in   = bv;       multiplier_in_t   = bt;
    mdld = 1; mrld = 1; rsclear = 1;
    step();
    idle_strobes();
    multiplicand_in_t = 0; multiplier_in_t = 0;
    check({tag, ".mr"},    32'(multiplierReg), 32'(bv));
    check({tag, ".mr_t"},  32'(multiplierReg_t), 32'(bt));
    check({tag, ".vld0"},  32'(product_valid), 32'd0);
    if (inj) begin
      rsload_t = 1; step(); rsload_t = 0;
    end
    for (int i = 0; i < W; i++) begin
      if (bv[i]) begin
        rsload = 1; step(); rsload = 0;
      end
      rsshr = 1; productDone = (i == W - 1); step();
      rsshr = 0; productDone = 0;
    end
    // Product taint arises only from a tainted MD actually added in, or injection.
    exp_pt = (at && (bv != 0)) || inj;
    check({tag, ".prod"},   32'(product), 32'(a * b));
    check({tag, ".prod_t"}, 32'(product_t), 32'(exp_pt));
    check({tag, ".vld"},    32'(product_valid), 32'd1);
    check({tag, ".vld_t"},  32'(product_valid_t), 32'd0);
  endtask

  initial begin
    rst = 0;
    multiplicand_in = 0; multiplicand_in_t = 0; multiplier_in = 0; multiplier_in_t = 0;
    idle_strobes();
    #12;
    check("rst.prod",  32'(product), 32'd0);
    check("rst.vld",   32'(product_valid), 32'd0);
    check("rst.mr",    32'(multiplierReg), 32'd0);
    check("rst.taint", 32'({product_t, product_valid_t, multiplierReg_t}), 32'd0);
    @(negedge clk); rst = 1;
    step();

    run_mult(13, 0, 11, 0, 0, "a13b11");
    run_mult(15, 0, 15, 0, 0, "a15b15");
    run_mult(5,  1, 3,  0, 0, "mdtaint");
    run_mult(9,  0, 6,  0, 1, "inj");
    run_mult(0,  0, 0,  1, 0, "zero");

    // Unshifted capture, then clear+add in one cycle wipes RS and its taint.
    multiplicand_in = 4'd15; mdld = 1; mrld = 1; multiplier_in = 4'd1; rsclear = 1;
    step(); idle_strobes();
    rsload = 1; rsload_t = 1; step(); idle_strobes();
    productDone = 1; step(); idle_strobes();
    check("noshr.prod",   32'(product), 32'hF0);
    check("noshr.prod_t", 32'(product_t), 32'd1);
    rsclear = 1; rsload = 1; step(); idle_strobes();
    check("clr.vld", 32'(product_valid), 32'd0);
    productDone = 1; step(); idle_strobes();
    check("clr.prod",   32'(product), 32'd0);
    check("clr.prod_t", 32'(product_t), 32'd0);
    check("clr.vld1",   32'(product_valid), 32'd1);

    // Tainted strobes that do not fire still raise the target taint.
    productDone_t = 1; step(); idle_strobes();
    check("pdt.prod",   32'(product), 32'd0);
    check("pdt.prod_t", 32'(product_t), 32'd1);
    check("pdt.vld_t",  32'(product_valid_t), 32'd1);
    mrld_t = 1; multiplier_in = 4'd7; step(); idle_strobes();
    check("mrt.mr",   32'(multiplierReg), 32'd1);
    check("mrt.mr_t", 32'(multiplierReg_t), 32'd1);

    for (int k = 0; k < 24; k++) begin
      run_mult($urandom_range(0, 15), ($urandom_range(0, 3) == 0),
               $urandom_range(0, 15), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 4) == 0), $sformatf("rnd%0d", k));
    end

    // Asynchronous reset in the middle of a multiply.
    multiplicand_in = 4'd11; multiplier_in = 4'd13; multiplier_in_t = 1;
    mdld = 1; mrld = 1; rsclear = 1; step(); idle_strobes();
    rsload = 1; rsload_t = 1; step(); idle_strobes();
    rsshr = 1; step(); idle_strobes();
    #2 rst = 0;
    #1;
    check("arst.prod",  32'(product), 32'd0);
    check("arst.vld",   32'(product_valid), 32'd0);
    check("arst.mr",    32'(multiplierReg), 32'd0);
    check("arst.taint", 32'({product_t, product_valid_t, multiplierReg_t}), 32'd0);
    step(); step();
    #1 rst = 1;
    productDone = 1; step(); idle_strobes();
    check("arst.rs0",   32'(product), 32'd0);
    check("arst.rs_t0", 32'(product_t), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
